// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: FSM state encodings and requester indices.
// Policy macro used by this block: MEM_ARBITER_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA  = 1'b1;

   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_sel.sv
// mem_arbiter_sel: combinational winner select between fetch and data.
// MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties, else data wins.
module mem_arbiter_sel
   import mem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   input  logic last,
`endif
   output logic any,
   output logic win
);

   assign any = req0 | req1;

   always_comb begin
      win = REQ_FETCH;
      if (req1 && !req0) begin
         win = REQ_DATA;
      end else if (req0 && req1) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         // tie goes to whichever port was not granted last
         win = (last == REQ_DATA) ? REQ_FETCH : REQ_DATA;
`else
         win = REQ_DATA;
`endif
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter onto a single issue/ready/data-ready port.
// MEM_ARBITER_ROUND_ROBIN_EN enables round-robin tie-break (fixed priority otherwise).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              I_clk,
   input  logic              I_reset,
   input  logic              I_req0,
   input  logic              I_req1,
   input  logic [ADDR_W-1:0] I_addr0,
   input  logic [ADDR_W-1:0] I_addr1,
   input  logic              I_we0,
   input  logic              I_we1,
   input  logic [DATA_W-1:0] I_wdata0,
   input  logic [DATA_W-1:0] I_wdata1,
   output logic              O_gnt0,
   output logic              O_gnt1,
   output logic              O_done0,
   output logic              O_done1,
   output logic [DATA_W-1:0] O_rdata0,
   output logic [DATA_W-1:0] O_rdata1,
   input  logic              I_mem_ready,
   output logic              O_execute,
   output logic [ADDR_W-1:0] O_addr,
   output logic              O_we,
   output logic [DATA_W-1:0] O_wdata,
   input  logic              I_data_ready,
   input  logic [DATA_W-1:0] I_rdata
);

   state_t     state_q;
   state_t     state_d;
   logic       win_q;
   logic       sel_any;
   logic       sel_win;
   logic [1:0] gnt_d;
   logic [1:0] done_d;
   logic       exec_d;
   logic       take;
   logic       cap;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic last_q;

   always_ff @(posedge I_clk or negedge I_reset) begin
      if (!I_reset) begin
         last_q <= REQ_DATA;
      end else if (take) begin
         last_q <= sel_win;
      end
   end
`endif

   mem_arbiter_sel u_sel (
      .req0 (I_req0),
      .req1 (I_req1),
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      .last (last_q),
`endif
      .any  (sel_any),
      .win  (sel_win)
   );

   always_ff @(posedge I_clk or negedge I_reset) begin
      if (!I_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      exec_d  = 1'b0;
      take    = 1'b0;
      cap     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (I_mem_ready && sel_any) begin
               take    = 1'b1;
               gnt_d   = req_onehot(sel_win);
               exec_d  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (O_we) begin
               done_d  = req_onehot(win_q);
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (I_data_ready) begin
               cap     = 1'b1;
               done_d  = req_onehot(win_q);
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge I_clk or negedge I_reset) begin
      if (!I_reset) begin
         O_gnt0    <= 1'b0;
         O_gnt1    <= 1'b0;
         O_done0   <= 1'b0;
         O_done1   <= 1'b0;
         O_execute <= 1'b0;
         O_addr    <= '0;
         O_we      <= 1'b0;
         O_wdata   <= '0;
         O_rdata0  <= '0;
         O_rdata1  <= '0;
         win_q     <= REQ_FETCH;
      end else begin
         O_gnt0    <= gnt_d[0];
         O_gnt1    <= gnt_d[1];
         O_done0   <= done_d[0];
         O_done1   <= done_d[1];
         O_execute <= exec_d;
         if (take) begin
            O_addr  <= sel_win ? I_addr1 : I_addr0;
            O_we    <= sel_win ? I_we1 : I_we0;
            O_wdata <= sel_win ? I_wdata1 : I_wdata0;
            win_q   <= sel_win;
         end
         // read data lands only on the port that owns the transaction
         if (cap) begin
            if (win_q == REQ_DATA) begin
               O_rdata1 <= I_rdata;
            end else begin
               O_rdata0 <= I_rdata;
            end
         end
      end
   end

endmodule
